fp_norm_round_seq: RTL and testbench
====================================

FP_NORM_ROUND_SEQ -- requirements
Module: fp_norm_round_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning packed IEEE 754 result width.
REQ-002 SHALL provide parameter EXP_BITS, default 8, meaning exponent field width.
REQ-003 SHALL provide parameter MANT_BITS, default 23, meaning fraction field width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; the clock and reset are the first two ports below.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  raw sum present on the inputs below.
REQ-008 in_ready  output  1  block can accept a raw sum.
REQ-009 sign_in  input  1  sign of the raw sum.
REQ-010 exp_in  input  EXP_BITS  biased exponent of the larger operand.
REQ-011 carry_in  input  1  mantissa adder carry-out.
REQ-012 mant_in  input  MANT_BITS+4  raw mantissa; bit fields:
- [MANT_BITS+3] hidden bit;
- [MANT_BITS+2:3] fraction;
- [2] guard; [1] round; [0] sticky.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 result  output  WIDTH  packed sign, exponent and fraction.
REQ-016 overflow, underflow, inexact, zero  output  1 each  result flags, valid with out_valid.

Function
REQ-017 SHALL implement FSM states IDLE, ALIGN, NORM, ROUND and OUT.
REQ-018 in_ready SHALL be 1 only in IDLE; a transfer is in_valid&in_ready at a rising edge, which captures all inputs and moves the FSM to ALIGN.
REQ-019 ALIGN, one cycle:
- if carry_in=1: shift the working mantissa right 1 with the shifted-out bit ORed into sticky, and increment exp;
- exp_in=0 SHALL be treated as 1;
- next state NORM.
REQ-020 NORM, each cycle: if hidden=1, or exp=1, or working mantissa=0, go to ROUND; otherwise shift left 1 (zero fill) and decrement exp. k denotes the number of shifts performed (0..MANT_BITS+3).
REQ-021 ROUND, one cycle, round-to-nearest-even: increment the fraction when guard&(round|sticky|fraction lsb); on fraction overflow with hidden=1, shift right 1 and increment exp; next state OUT.
REQ-022 out_valid SHALL rise 3+k rising edges after the accepting edge and stay 1 in OUT.
REQ-023 result and flags SHALL hold stable in OUT until out_valid&out_ready; that edge returns the FSM to IDLE (in_ready=1 in the next cycle).
REQ-024 inexact SHALL be 1 when any of guard, round or sticky was nonzero entering ROUND.
REQ-025 Exponent reaching 2^EXP_BITS-1 after ALIGN or ROUND SHALL produce result {sign_in, all-ones exponent, zero fraction}, with overflow=1 and inexact=1.
REQ-026 Final hidden bit 0 with a nonzero fraction SHALL produce exponent field 0 (denormal); underflow SHALL be 1 when the result is also inexact.
REQ-027 An all-zero working mantissa SHALL produce result 0 (+0) with zero=1 and k=0.
REQ-028 exp_in all-ones SHALL bypass normalization and rounding (k=0):
- fraction nonzero: result 0x7FC00000;
- fraction zero: result {sign_in, infinity};
- all flags 0.
REQ-029 in_valid asserted outside IDLE SHALL be ignored; no input is captured.

Reset
REQ-030 rst=1 SHALL, immediately and asynchronously, force the FSM to IDLE; out_valid, result and all flags to 0; and in_ready to 1. This applies in any state, including mid-NORM or OUT.
REQ-031 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 1.0+1.0: exp_in=0x7F, carry_in=1, mant_in hidden=0, rest 0 -> result 0x40000000, flags 0, out_valid 3 edges after accept.
REQ-033 0.25 cancellation: exp_in=0x7F, carry_in=0, mant_in bit[MANT_BITS+1]=1 only -> k=2, result 0x3E800000, out_valid 5 edges after accept.
REQ-034 RNE ties: exp_in=0x7F, hidden=1, guard=1, round=0, sticky=0:
- fraction lsb=1 -> result 0x3F800002, inexact=1;
- fraction lsb=0 -> result 0x3F800000, inexact=1.
REQ-035 Overflow: exp_in=0xFE, carry_in=1 -> result 0x7F800000, overflow=1, inexact=1.
REQ-036 Zero and specials:
- mant_in=0, carry_in=0 -> result 0x00000000, zero=1;
- exp_in=0xFF with fraction nonzero -> result 0x7FC00000.
REQ-037 Backpressure and reset:
- out_ready=0 for 5 cycles -> result stays constant and in_ready=0;
- rst pulsed during NORM -> out_valid=0 immediately, in_ready=1 after release, and the next transfer completes correctly.

Source files
------------

// File: rtl/fp_norm_round_seq.sv
// Sequential normalise-and-round stage for a floating-point adder: takes the raw
// sum (carry, mantissa with guard/round/sticky) and produces a packed IEEE result.
module fp_norm_round_seq #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_in,
  input  logic [EXP_BITS-1:0]    exp_in,
  input  logic                   carry_in,
  input  logic [MANT_BITS+3:0]   mant_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact,
  output logic                   zero,
  output logic [2:0]             state_dbg
);

  localparam int MW = MANT_BITS + 4;
  // One spare exponent bit so a rounding carry past all-ones is still visible.
  localparam int EW = EXP_BITS + 1;
  localparam logic [EW-1:0] EXP_ONE = EW'(1);
  localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_BITS{1'b1}}};

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid, once raised, holds with stable data until that edge.
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_NORM, S_ROUND, S_OUT} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  special_q, special_d;
  logic                  carry_q, carry_d;
  logic [EW-1:0]         exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [3:0]            flags_q, flags_d;

  logic                  norm_done;
  logic [EW-1:0]         exp_base;
  logic                  rnd_inc, grs_nz;
  logic [MANT_BITS+1:0]  rnd_sum;
  logic [MANT_BITS:0]    rnd_mant;
  logic [EW-1:0]         rnd_exp;
  logic [WIDTH-1:0]      rnd_result;
  logic [3:0]            rnd_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      carry_q   <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      special_q <= special_d;
      carry_q   <= carry_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign norm_done = special_q | mant_q[MW-1] | (exp_q == EXP_ONE) | (mant_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_NORM;
      S_NORM:  if (norm_done) state_d = S_ROUND;
      S_ROUND: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Round-to-nearest-even on {hidden, fraction}; a carry out renormalises by one.
  always_comb begin
    grs_nz  = |mant_q[2:0];
    rnd_inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd_sum = {1'b0, mant_q[MW-1:3]} + (MANT_BITS+2)'(rnd_inc);
    if (rnd_sum[MANT_BITS+1]) begin
      rnd_mant = rnd_sum[MANT_BITS+1:1];
      rnd_exp  = exp_q + EXP_ONE;
    end else begin
      rnd_mant = rnd_sum[MANT_BITS:0];
      rnd_exp  = exp_q;
    end
    rnd_flags = '0;
    if (special_q) begin
      if (mant_q[MW-2:3] != '0)
        rnd_result = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
      else
        rnd_result = {sign_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
    end else if (mant_q == '0) begin
      rnd_result = '0;
      rnd_flags  = 4'b0001;
    end else if (rnd_exp >= EXP_MAX) begin
      rnd_result = {sign_q, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      rnd_flags  = 4'b1010;
    end else begin
      rnd_result = {sign_q, rnd_mant[MANT_BITS] ? rnd_exp[EXP_BITS-1:0] : {EXP_BITS{1'b0}},
                    rnd_mant[MANT_BITS-1:0]};
      rnd_flags  = {1'b0, ~rnd_mant[MANT_BITS] & grs_nz, grs_nz,
                    ~rnd_mant[MANT_BITS] & (rnd_mant[MANT_BITS-1:0] == '0)};
    end
  end

  assign exp_base = (exp_q == '0) ? EXP_ONE : exp_q;

  always_comb begin
    sign_d    = sign_q;
    special_d = special_q;
    carry_d   = carry_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    result_d  = result_q;
    flags_d   = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d    = sign_in;
          special_d = &exp_in;
          carry_d   = carry_in;
          exp_d     = {1'b0, exp_in};
          mant_d    = mant_in;
        end
      end
      S_ALIGN: begin
        if (!special_q) begin
          exp_d = exp_base;
          if (carry_q) begin
            mant_d = {1'b1, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
            exp_d  = exp_base + EXP_ONE;
          end
        end
      end
      S_NORM: begin
        if (!norm_done) begin
          mant_d = {mant_q[MW-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end
      end
      S_ROUND: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
    state_dbg = state_q;
    result    = result_q;
    overflow  = flags_q[3];
    underflow = flags_q[2];
    inexact   = flags_q[1];
    zero      = flags_q[0];
  end

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Bench for fp_norm_round_seq: directed corner cases plus random raw sums,
// scored against an arithmetic reference model through an expected queue.
module tb_fp_norm_round_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        carry_in = 1'b0;
  logic [26:0] mant_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow, inexact, zero;
  logic [2:0]  state_dbg;

  int errors = 0;
  int n_checks = 0;
  int cyc = 0;
  int rdy_mode = 0;

  // Entry: {result[31:0], flags{ovf,udf,inx,zero}[3:0], k[7:0]}
  logic [43:0] exp_q[$];
  int          acc_q[$];
  logic [43:0] cur;
  bit          in_out = 1'b0;

  fp_norm_round_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .carry_in(carry_in), .mant_in(mant_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact), .zero(zero),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #900000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Value view: sig = {carry, mant} scaled so bit 26 is the unit; normalise by
  // locating the leading one directly, then RNE on the three low bits.
  function automatic logic [43:0] model(input logic s, input logic [7:0] e_in,
                                        input logic c, input logic [26:0] m);
    logic [27:0] sig;
    logic [24:0] kept;
    logic [2:0]  rem;
    logic [31:0] res;
    logic [3:0]  flg;
    int e, p, k;
    bit inx;
    sig = {c, m};
    k = 0;
    flg = '0;
    if (e_in == 8'hFF) begin
      res = (m[25:3] != 0) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
      return {res, flg, 8'd0};
    end
    if (sig == 0) return {32'h0, 4'b0001, 8'd0};
    e = (e_in == 0) ? 1 : int'(e_in);
    p = 0;
    for (int i = 27; i >= 0; i--) if (sig[i]) begin p = i; break; end
    if (p == 27) begin
      sig = {1'b0, sig[27:2], sig[1] | sig[0]};
      e = e + 1;
    end else if (p < 26) begin
      k = 26 - p;
      if (k > e - 1) k = e - 1;
      sig = sig << k;
      e = e - k;
    end
    kept = {1'b0, sig[26:3]};
    rem  = sig[2:0];
    inx  = (rem != 0);
    if (rem > 3'd4 || (rem == 3'd4 && kept[0])) kept = kept + 25'd1;
    if (kept[24]) begin kept = kept >> 1; e = e + 1; end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'h0};
      flg = 4'b1010;
    end else if (kept[23]) begin
      res = {s, 8'(e), kept[22:0]};
      flg = {2'b00, inx, 1'b0};
    end else begin
      res = {s, 8'h00, kept[22:0]};
      flg = {1'b0, inx, inx, kept[22:0] == 0};
    end
    return {res, flg, 8'(k)};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic s, input logic [7:0] e, input logic c,
                      input logic [26:0] m, input bit garbage);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin @(negedge clk); waited++; end
    if (!in_ready) begin
      n_checks++; errors++;
      $display("FAIL accept_timeout: in_ready still %0b after %0d cycles, need 1", in_ready, waited);
      return;
    end
    sign_in = s; exp_in = e; carry_in = c; mant_in = m; in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    exp_q.push_back(model(s, e, c, m));
    if (garbage) begin
      waited = 0;
      forever begin
        @(negedge clk);
        if ((out_valid && out_ready) || waited > 300) break;
        sign_in = 1'($urandom()); exp_in = 8'($urandom()); carry_in = 1'($urandom());
        mant_in = 27'($urandom());
        waited++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      n_checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, need 0", exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    int acc;
    @(negedge clk);
    if (rst) begin
      in_out = 1'b0;
    end else if (out_valid) begin
      if (!in_out) begin
        if (exp_q.size() == 0) begin
          n_checks++; errors++;
          $display("FAIL unexpected_output: result %0h with empty expected queue", result);
        end else begin
          cur = exp_q.pop_front();
          acc = acc_q.pop_front();
          chk("result", 64'(result), 64'(cur[43:12]));
          chk("flags", 64'({overflow, underflow, inexact, zero}), 64'(cur[11:8]));
          chk("latency", 64'(cyc - acc), 64'(3 + int'(cur[7:0])));
        end
        in_out = 1'b1;
      end else begin
        chk("hold_result", 64'(result), 64'(cur[43:12]));
        chk("hold_flags", 64'({overflow, underflow, inexact, zero}), 64'(cur[11:8]));
        chk("in_ready_in_out", 64'(in_ready), 64'(0));
      end
      if (out_ready) in_out = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  e;
    logic [26:0] m;
    int t;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_flags", 64'({overflow, underflow, inexact, zero}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    send(0, 8'h7F, 1, 27'h0, 0);                                   // 1.0 + 1.0
    send(0, 8'h7F, 0, 27'h1 << 24, 0);                             // 0.25 cancellation
    send(0, 8'h7F, 0, (27'h1 << 26) | (27'h1 << 3) | (27'h1 << 2), 0); // tie, odd
    send(0, 8'h7F, 0, (27'h1 << 26) | (27'h1 << 2), 0);            // tie, even
    send(0, 8'hFE, 1, 27'h1 << 26, 0);                             // overflow
    send(1, 8'h7F, 0, 27'h0, 0);                                   // zero
    send(0, 8'hFF, 0, 27'h1 << 10, 0);                             // NaN
    send(1, 8'hFF, 0, 27'h0, 0);                                   // infinity
    send(0, 8'h00, 0, 27'h0000_01C, 0);                            // denormal, inexact
    send(0, 8'h03, 0, 27'h0000_100, 0);                            // shift stops at exp 1
    drain();

    // Backpressure: result must hold while out_ready stays low.
    rdy_mode = 2;
    send(0, 8'h80, 0, (27'h1 << 26) | 27'h5A5, 1);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    drain();

    // Reset in the middle of a long normalisation.
    send(0, 8'h7F, 0, 27'h1, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_norm_state", 64'(state_dbg), 64'(2));
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_result", 64'(result), 64'(0));
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    send(1, 8'h90, 1, (27'h1 << 26) | 27'h3, 0);
    drain();

    // Random raw sums with random consumer backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0: e = 8'($urandom_range(0, 3));
        1: e = 8'hFE;
        2: e = 8'hFF;
        3: e = 8'($urandom_range(240, 254));
        default: e = 8'($urandom_range(1, 254));
      endcase
      m = 27'($urandom()) >> $urandom_range(0, 27);
      if ($urandom_range(0, 15) == 0) m = '0;
      send(1'($urandom()), e, $urandom_range(0, 3) == 0, m, $urandom_range(0, 1) == 1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
